// File: rtl/ddr_score_keeper.sv
// Score keeper for the DDR game: turns per-arrow hit/miss judgements into BCD score,
// combo, best combo and miss count, and runs the IDLE/PLAY/OVER game-state machine.
module ddr_score_keeper #(
    parameter int MISS_LIMIT = 10,
    parameter int COMBO_T1   = 10,
    parameter int COMBO_T2   = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        judge_valid,
    input  logic        correct_input,
    output logic [15:0] score_bcd,
    output logic [7:0]  combo_bcd,
    output logic [7:0]  max_combo_bcd,
    output logic [6:0]  miss_count,
    output logic        playing,
    output logic        game_over
);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t      state, state_next;
    logic [15:0] score_next;
    logic [7:0]  combo_next;
    logic [7:0]  max_combo_next;
    logic [6:0]  miss_next;
    logic [6:0]  combo_bin;
    logic [1:0]  points;

    // Four-digit BCD add of a small increment; any carry out of the thousands digit pins at 9999.
    function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [1:0] pts);
        logic [15:0] r;
        logic [4:0]  d;
        logic        carry;
        r     = '0;
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[i*4 +: 4]} + {4'd0, carry} + ((i == 0) ? {3'd0, pts} : 5'd0);
            if (d > 5'd9) begin
                r[i*4 +: 4] = 4'(d - 5'd10);
                carry       = 1'b1;
            end else begin
                r[i*4 +: 4] = d[3:0];
                carry       = 1'b0;
            end
        end
        if (carry)
            r = 16'h9999;
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] a);
        if (a == 8'h99)
            return a;
        else if (a[3:0] == 4'd9)
            return {a[7:4] + 4'd1, 4'd0};
        else
            return {a[7:4], a[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_to_bin(input logic [7:0] a);
        return 7'(a[7:4]) * 7'd10 + 7'(a[3:0]);
    endfunction

    assign combo_bin = bcd_to_bin(combo_bcd);

    always_comb begin
        points = 2'd3;
        if (combo_bin < 7'(COMBO_T1))
            points = 2'd1;
        else if (combo_bin < 7'(COMBO_T2))
            points = 2'd2;
    end

    // start outranks any judgement in the same cycle, in every state.
    always_comb begin
        state_next     = state;
        score_next     = score_bcd;
        combo_next     = combo_bcd;
        max_combo_next = max_combo_bcd;
        miss_next      = miss_count;
        if (start) begin
            state_next     = PLAY;
            score_next     = '0;
            combo_next     = '0;
            max_combo_next = '0;
            miss_next      = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (judge_valid) begin
                        if (correct_input) begin
                            score_next = bcd_add_sat(score_bcd, points);
                            combo_next = bcd_inc_sat(combo_bcd);
                            // BCD codes order the same as their decimal values.
                            if (combo_next > max_combo_bcd)
                                max_combo_next = combo_next;
                        end else begin
                            combo_next = '0;
                            miss_next  = miss_count + 7'd1;
                            if (miss_next == 7'(MISS_LIMIT))
                                state_next = OVER;
                        end
                    end
                end
                IDLE, OVER: ;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            score_bcd     <= '0;
            combo_bcd     <= '0;
            max_combo_bcd <= '0;
            miss_count    <= '0;
        end else begin
            state         <= state_next;
            score_bcd     <= score_next;
            combo_bcd     <= combo_next;
            max_combo_bcd <= max_combo_next;
            miss_count    <= miss_next;
        end
    end

    assign playing   = (state == PLAY);
    assign game_over = (state == OVER);

endmodule

// File: tb/tb_ddr_score_keeper.sv
// Bench for ddr_score_keeper: directed game scenarios plus random play, checked by a
// scoreboard fed from an integer-arithmetic model of the scoring rules.
module tb_ddr_score_keeper;

    localparam int MISS_LIMIT = 10;
    localparam int COMBO_T1   = 10;
    localparam int COMBO_T2   = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        judge_valid = 1'b0;
    logic        correct_input = 1'b0;
    logic [15:0] score_bcd;
    logic [7:0]  combo_bcd;
    logic [7:0]  max_combo_bcd;
    logic [6:0]  miss_count;
    logic        playing;
    logic        game_over;

    ddr_score_keeper #(
        .MISS_LIMIT(MISS_LIMIT),
        .COMBO_T1  (COMBO_T1),
        .COMBO_T2  (COMBO_T2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .judge_valid  (judge_valid),
        .correct_input(correct_input),
        .score_bcd    (score_bcd),
        .combo_bcd    (combo_bcd),
        .max_combo_bcd(max_combo_bcd),
        .miss_count   (miss_count),
        .playing      (playing),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] score;
        logic [7:0]  combo;
        logic [7:0]  maxc;
        logic [6:0]  miss;
        logic        play;
        logic        over;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Model state: plain integers, mode 0 = idle, 1 = play, 2 = over.
    int m_mode = 0, m_score = 0, m_combo = 0, m_max = 0, m_miss = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_score = 0; m_combo = 0; m_max = 0; m_miss = 0;
    endfunction

    function automatic void model_step(bit s, bit jv, bit ci);
        int pts;
        if (s) begin
            m_mode = 1; m_score = 0; m_combo = 0; m_max = 0; m_miss = 0;
        end else if (jv && m_mode == 1) begin
            if (ci) begin
                pts = (m_combo < COMBO_T1) ? 1 : (m_combo < COMBO_T2) ? 2 : 3;
                m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
                m_combo = (m_combo >= 99) ? 99 : m_combo + 1;
                if (m_combo > m_max) m_max = m_combo;
            end else begin
                m_combo = 0;
                m_miss++;
                if (m_miss == MISS_LIMIT) m_mode = 2;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.score = to_bcd(m_score);
        e.combo = to_bcd(m_combo)[7:0];
        e.maxc  = to_bcd(m_max)[7:0];
        e.miss  = 7'(m_miss);
        e.play  = (m_mode == 1);
        e.over  = (m_mode == 2);
        return e;
    endfunction

    // One clock of stimulus; outputs settle by the time this returns.
    task automatic cyc(bit s, bit jv, bit ci);
        start = s; judge_valid = jv; correct_input = ci;
        if (s || jv) begin
            model_step(s, jv, ci);
            q.push_back(model_out());
        end
        @(posedge clk);
        #2;
        start = 1'b0; judge_valid = 1'b0; correct_input = 1'($urandom);
    endtask

    task automatic hits(int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 1);
    endtask

    task automatic chk_all(string tag, logic [15:0] s, logic [7:0] c, logic [7:0] mc,
                           logic [6:0] m, logic p, logic o);
        chk({tag, ".score"}, 32'(score_bcd), 32'(s));
        chk({tag, ".combo"}, 32'(combo_bcd), 32'(c));
        chk({tag, ".max"}, 32'(max_combo_bcd), 32'(mc));
        chk({tag, ".miss"}, 32'(miss_count), 32'(m));
        chk({tag, ".playing"}, 32'(playing), 32'(p));
        chk({tag, ".game_over"}, 32'(game_over), 32'(o));
    endtask

    // Monitor: every cycle that carried a start or judgement has one queued expectation.
    exp_t mon_e;
    always @(posedge clk) begin
        if (rst_n && (start || judge_valid)) begin
            #1;
            if (q.size() == 0) begin
                chk("sb.underflow", 32'(1), 32'(0));
            end else begin
                mon_e = q.pop_front();
                chk("sb.score", 32'(score_bcd), 32'(mon_e.score));
                chk("sb.combo", 32'(combo_bcd), 32'(mon_e.combo));
                chk("sb.max", 32'(max_combo_bcd), 32'(mon_e.maxc));
                chk("sb.miss", 32'(miss_count), 32'(mon_e.miss));
                chk("sb.playing", 32'(playing), 32'(mon_e.play));
                chk("sb.game_over", 32'(game_over), 32'(mon_e.over));
            end
        end else begin
            #1;
        end
        chk("exclusive", 32'(playing & game_over), 32'(0));
    end

    initial begin
        #3;
        chk_all("reset", 16'h0000, 8'h00, 8'h00, 7'd0, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        cyc(0, 0, 0);

        // Build score 42 with combo 5, then reset asynchronously mid-game.
        cyc(1, 0, 0);
        hits(10); cyc(0, 1, 0);
        hits(10); cyc(0, 1, 0);
        hits(10); cyc(0, 1, 0);
        hits(7);  cyc(0, 1, 0);
        hits(5);
        chk_all("pre_reset", 16'h0042, 8'h05, 8'h10, 7'd4, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 16'h0000, 8'h00, 8'h00, 7'd0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
        cyc(0, 1, 1);
        chk_all("idle_hit", 16'h0000, 8'h00, 8'h00, 7'd0, 1'b0, 1'b0);

        // Twelve hits: BCD carry at hit ten, double points afterwards.
        cyc(1, 0, 0);
        hits(9);
        chk("hit9.score", 32'(score_bcd), 32'(16'h0009));
        hits(1);
        chk("hit10.score", 32'(score_bcd), 32'(16'h0010));
        hits(2);
        chk_all("hit12", 16'h0014, 8'h12, 8'h12, 7'd0, 1'b1, 1'b0);

        // Miss resets combo but not best combo.
        cyc(1, 0, 0);
        hits(5); cyc(0, 1, 0); hits(2);
        chk_all("miss", 16'h0007, 8'h02, 8'h05, 7'd1, 1'b1, 1'b0);

        // Ten misses end the game; later hits are ignored; start resumes play.
        cyc(1, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 1, 0);
        chk("miss9.playing", 32'(playing), 32'(1));
        cyc(0, 1, 0);
        chk_all("over", 16'h0000, 8'h00, 8'h00, 7'd10, 1'b0, 1'b1);
        hits(3);
        chk_all("over_hits", 16'h0000, 8'h00, 8'h00, 7'd10, 1'b0, 1'b1);
        cyc(1, 0, 0);
        chk_all("restart", 16'h0000, 8'h00, 8'h00, 7'd0, 1'b1, 1'b0);

        // Saturation: 10*1 + 20*2 + 3316*3 = 9998, then one more 3-point hit.
        hits(3346);
        chk_all("pre_sat", 16'h9998, 8'h99, 8'h99, 7'd0, 1'b1, 1'b0);
        hits(1);
        chk_all("sat", 16'h9999, 8'h99, 8'h99, 7'd0, 1'b1, 1'b0);

        // start collides with a hit: start wins.
        cyc(1, 0, 0);
        hits(15);
        chk("pre_collide.score", 32'(score_bcd), 32'(16'h0020));
        cyc(1, 1, 1);
        chk_all("collide", 16'h0000, 8'h00, 8'h00, 7'd0, 1'b1, 1'b0);

        // Random play, including occasional restarts and game-overs.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0)
                cyc(0, 0, 1'($urandom));
            else
                cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 4) != 0));
        end

        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("sb.drained", 32'(q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
